// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router constants and arbiter state type
package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - per-input virtual-channel FIFO, head visible at rd_data
module vc_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full refuses writes even when popped in the same cycle: no bypass path.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/vc_output_port.sv
// rtl/vc_output_port.sv - NoC output port: per-input VC FIFOs, round-robin
// wormhole arbiter and a registered valid/ready output link
module vc_output_port
  import noc_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_IN    = 5,
  parameter int VC_DEPTH  = 4,
  parameter int LOCAL_IDX = NUM_IN - 1,
  parameter int PRIO_MODE = 1,
  localparam int CW       = $clog2(VC_DEPTH + 1),
  localparam int IW       = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_last,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_IN*CW-1:0]     vc_count
);

  logic [NUM_IN-1:0] full, empty, pop, req;
  logic [DATA_W:0]   head [NUM_IN];

  arb_state_e        state_q;
  logic [IW-1:0]     ptr_q, owner_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q, out_valid_q;

  logic              load, sel_valid;
  logic [IW-1:0]     sel_idx;
  logic [DATA_W:0]   sel_flit;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_vc
    assign in_ready[g] = !full[g] && !rst;

    vc_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid[g] && in_ready[g]),
      .wr_data ({in_last[g], in_data[g*DATA_W +: DATA_W]}),
      .rd_en   (pop[g]),
      .rd_data (head[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .count   (vc_count[g*CW +: CW])
    );
  end

  assign load = !out_valid_q || out_ready;

  // Downward scan so the port closest after the pointer is the last, winning, hit.
  always_comb begin
    req = ~empty;
    if (PRIO_MODE != 0 && (req & ~(NUM_IN'(1) << LOCAL_IDX)) != '0) begin
      req[LOCAL_IDX] = 1'b0;
    end
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (state_q == ARB_LOCKED) begin
      sel_valid = !empty[owner_q];
      sel_idx   = owner_q;
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        if (req[(int'(ptr_q) + k) % NUM_IN]) begin
          sel_valid = 1'b1;
          sel_idx   = IW'((int'(ptr_q) + k) % NUM_IN);
        end
      end
    end
  end

  assign sel_flit = head[sel_idx];

  always_comb begin
    pop = '0;
    if (load && sel_valid) pop[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IW'(NUM_IN - 1);
      owner_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      if (sel_valid) begin
        out_data_q  <= sel_flit[DATA_W-1:0];
        out_last_q  <= sel_flit[DATA_W];
        out_valid_q <= 1'b1;
        if (sel_flit[DATA_W]) begin
          state_q <= ARB_IDLE;
          ptr_q   <= sel_idx;
        end else begin
          state_q <= ARB_LOCKED;
          owner_q <= sel_idx;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vc_output_port.sv
// tb/tb_vc_output_port.sv - self-checking bench for vc_output_port
module tb_vc_output_port;

  localparam int DW   = 32;
  localparam int NI   = 5;
  localparam int DEP  = 4;
  localparam int CW   = 3;
  localparam int LI   = 4;
  localparam int PRIO = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_last, in_valid, in_ready;
  logic [DW-1:0]    out_data;
  logic             out_last, out_valid, out_ready;
  logic [NI*CW-1:0] vc_count;

  always #5 clk = ~clk;

  vc_output_port #(
    .DATA_W    (DW),
    .NUM_IN    (NI),
    .VC_DEPTH  (DEP),
    .LOCAL_IDX (LI),
    .PRIO_MODE (PRIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vc_count  (vc_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: queues of {last,data}, output register, lock and pointer.
  logic [DW:0]   q [NI][$];
  bit            m_ov, m_ol, m_locked;
  logic [DW-1:0] m_od;
  int            m_ptr, m_owner;
  logic [DW-1:0] delivered [$];
  logic [NI-1:0] last_in_ready;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) q[i].delete();
    m_ov = 0; m_ol = 0; m_od = '0; m_locked = 0; m_ptr = NI - 1; m_owner = 0;
  endtask

  task automatic model_edge();
    bit acc [NI];
    bit load, others;
    int sel;
    logic [DW:0] f;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) acc[i] = in_valid[i] && (q[i].size() < DEP);
    load = !m_ov || out_ready;
    if (m_ov && out_ready) delivered.push_back(m_od);
    sel = -1;
    if (m_locked) begin
      if (q[m_owner].size() > 0) sel = m_owner;
    end else begin
      others = 0;
      for (int i = 0; i < NI; i++) if (i != LI && q[i].size() > 0) others = 1;
      for (int k = 1; k <= NI; k++) begin
        if (sel < 0 && q[(m_ptr + k) % NI].size() > 0 &&
            !(PRIO != 0 && (m_ptr + k) % NI == LI && others)) sel = (m_ptr + k) % NI;
      end
    end
    if (load) begin
      if (sel >= 0) begin
        f = q[sel].pop_front();
        m_od = f[DW-1:0]; m_ol = f[DW]; m_ov = 1;
        if (f[DW]) begin m_locked = 0; m_ptr = sel; end
        else begin m_locked = 1; m_owner = sel; end
      end else m_ov = 0;
    end
    for (int i = 0; i < NI; i++)
      if (acc[i]) q[i].push_back({in_last[i], in_data[i*DW +: DW]});
  endtask

  task automatic compare();
    logic [NI-1:0]    er;
    logic [NI*CW-1:0] ec;
    for (int i = 0; i < NI; i++) begin
      er[i] = !rst && (q[i].size() < DEP);
      ec[i*CW +: CW] = CW'(q[i].size());
    end
    last_in_ready = in_ready;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, m_ol);
    check("in_ready", in_ready, er);
    check("vc_count", vc_count, ec);
  endtask

  task automatic step();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = '0; in_last = '0; in_data = '0;
  endtask

  task automatic put(input int p, input int seq, input bit last);
    in_valid[p] = 1'b1;
    in_last[p]  = last;
    in_data[p*DW +: DW] = {8'(p), 24'(seq)};
  endtask

  task automatic check_ports(input string tag, input int exp_ports [$]);
    check({tag, "_count"}, 64'(delivered.size()), 64'(exp_ports.size()));
    for (int k = 0; k < exp_ports.size() && k < delivered.size(); k++)
      check(tag, 64'(delivered[k][31:24]), 64'(exp_ports[k]));
  endtask

  int j;

  initial begin
    rst = 1'b1; out_ready = 1'b1; idle_in(); model_reset();
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    // single flit from port 2
    put(2, 1, 1'b1); in_data[2*DW +: DW] = 32'hA5A5_0001;
    step();
    idle_in();
    step();
    #1 check("single_valid", out_valid, 1);
    check("single_data", out_data, 32'hA5A5_0001);
    check("single_last", out_last, 1);
    step();
    #1 check("single_bubble", out_valid, 0);

    // round-robin fairness after a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle_in();
      for (int p = 0; p < 4; p++) put(p, c, 1'b1);
      step();
    end
    idle_in(); delivered.delete(); out_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    check_ports("rr_order", '{0,1,2,3,0,1,2,3,0,1,2,3,0,1,2,3});

    // local port yields to port 0
    out_ready = 1'b0; delivered.delete();
    for (int c = 0; c < 2; c++) begin
      idle_in(); put(0, c, 1'b1); put(LI, c, 1'b1); step();
    end
    idle_in(); out_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check_ports("local_prio", '{0,0,4,4});

    // wormhole lock with a gap before the tail
    delivered.delete();
    idle_in(); put(1, 0, 1'b0); step();
    idle_in(); put(1, 1, 1'b0); put(3, 0, 1'b1); step();
    idle_in(); step(); step();
    put(1, 2, 1'b1); step();
    idle_in();
    for (int c = 0; c < 6; c++) step();
    check_ports("wormhole", '{1,1,1,3});

    // backpressure until port 0 fills
    delivered.delete(); out_ready = 1'b0; j = 0;
    for (int c = 0; c < 8; c++) begin
      idle_in(); if (j < 6) put(0, 100 + j, 1'b1);
      step();
      if (in_valid[0] && last_in_ready[0]) j++;
    end
    #1 check("bp_hold_data", out_data, {8'd0, 24'd100});
    check("bp_full_count", vc_count[CW-1:0], DEP);
    check("bp_full_ready", in_ready[0], 0);
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      idle_in(); if (j < 6) put(0, 100 + j, 1'b1);
      step();
      if (in_valid[0] && last_in_ready[0]) j++;
    end
    check("bp_count", 64'(delivered.size()), 6);
    for (int k = 0; k < 6 && k < delivered.size(); k++)
      check("bp_order", delivered[k], {8'd0, 24'(100 + k)});

    // reset in the middle of a locked packet
    out_ready = 1'b0;
    idle_in(); put(2, 0, 1'b0); put(1, 0, 1'b1); step();
    idle_in(); put(2, 1, 1'b0); step();
    idle_in(); rst = 1'b1;
    #1 check("rst_in_ready", in_ready, 0);
    step(); rst = 1'b0;
    #1 check("rst_out_valid", out_valid, 0);
    check("rst_vc_count", vc_count, 0);
    delivered.delete(); out_ready = 1'b1;
    put(0, 0, 1'b1); put(1, 0, 1'b1); put(2, 0, 1'b1); step();
    idle_in();
    for (int c = 0; c < 6; c++) step();
    check_ports("rst_first", '{0,1,2});

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < NI; p++) begin
        in_valid[p] = $urandom_range(0, 1);
        in_last[p]  = ($urandom_range(0, 2) == 0);
        in_data[p*DW +: DW] = $urandom;
      end
      step();
    end
    rst = 1'b0; idle_in(); out_ready = 1'b1;
    for (int c = 0; c < 30; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
